// File: rtl/ternary_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ternary_pkg
// Description : Shared trit type and encodings for the serial ternary subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T0 = 2'b00;
    localparam trit_t T1 = 2'b01;
    localparam trit_t T2 = 2'b10;
    localparam trit_t TX = 2'b11;

endpackage
`default_nettype wire

// File: rtl/trit_sub_cell.sv
`default_nettype none
// ============================================================================
// Module      : trit_sub_cell
// Description : One-digit ternary subtractor d = (a - b - borrow_in) mod 3.
// Revision    : 1.0 - initial release
// ============================================================================
module trit_sub_cell
    import ternary_pkg::*;
(
    input  trit_t a,
    input  trit_t b,
    input  logic  borrow_in,
    output trit_t d,
    output logic  borrow_next,
    output logic  illegal
);

    // Biased by +3 so the difference stays non-negative: 0..2 means a borrow.
    logic [2:0] w_sum;

    assign illegal = (a == TX) || (b == TX);
    assign w_sum   = {1'b0, a} + 3'd3 - {1'b0, b} - {2'b00, borrow_in};

    always_comb begin
        d           = T0;
        borrow_next = 1'b0;
        if (!illegal) begin
            case (w_sum)
                3'd0:    begin d = T0; borrow_next = 1'b1; end
                3'd1:    begin d = T1; borrow_next = 1'b1; end
                3'd2:    begin d = T2; borrow_next = 1'b1; end
                3'd3:    begin d = T0; borrow_next = 1'b0; end
                3'd4:    begin d = T1; borrow_next = 1'b0; end
                3'd5:    begin d = T2; borrow_next = 1'b0; end
                default: begin d = T0; borrow_next = 1'b0; end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ternary_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : ternary_serial_sub
// Description : Trit-serial ternary subtractor, LS trit first, one-entry
//               registered output stage with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ternary_serial_sub
    import ternary_pkg::*;
#(
    parameter int MAX_TRITS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_first,
    input  logic       in_last,
    input  logic [1:0] a_trit,
    input  logic [1:0] b_trit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] d_trit,
    output logic       out_last,
    output logic       borrow_out,
    output logic       err,
    output logic       ovf
);

    localparam int                c_cnt_w   = $clog2(MAX_TRITS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_TRITS);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic               r_borrow;

    logic               r_out_valid;
    trit_t              r_d;
    logic               r_last;
    logic               r_borrow_out;
    logic               r_err;
    logic               r_ovf;

    logic               w_accept;
    logic               w_first;
    logic               w_borrow_in;
    logic               w_ovf;
    logic               w_term;
    trit_t              w_d;
    logic               w_bn;
    logic               w_illegal;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    assign out_valid  = r_out_valid;
    assign d_trit     = r_d;
    assign out_last   = r_last;
    assign borrow_out = r_borrow_out;
    assign err        = r_err;
    assign ovf        = r_ovf;

    trit_sub_cell u_cell (
        .a           (a_trit),
        .b           (b_trit),
        .borrow_in   (w_borrow_in),
        .d           (w_d),
        .borrow_next (w_bn),
        .illegal     (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept && !w_term) w_state_next = c_st_busy;
            c_st_busy: if (w_accept && w_term)  w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // A beat arriving with no word open starts one, whatever in_first says.
    always_comb begin
        w_first      = in_first || (r_state == c_st_idle);
        w_borrow_in  = w_first ? 1'b0 : r_borrow;
        w_count_next = w_first ? c_cnt_one : (r_count + c_cnt_one);
        w_ovf        = (w_count_next == c_cnt_max) && !in_last;
        w_term       = in_last || w_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_count  <= w_term ? '0   : w_count_next;
            r_borrow <= w_term ? 1'b0 : w_bn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_d          <= T0;
            r_last       <= 1'b0;
            r_borrow_out <= 1'b0;
            r_err        <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_d          <= w_d;
            r_last       <= w_term;
            r_borrow_out <= w_term && w_bn;
            r_err        <= w_illegal;
            r_ovf        <= w_ovf;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
